// File: rtl/transformer_accel_pkg.sv
// Shared types and defaults for the transformer accelerator datapath blocks.
package transformer_accel_pkg;

  localparam int BITWIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } row_state_t;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Row storage: one synchronous write port and one combinational read port.
// Contents are deliberately not reset; the control path tracks what is valid.
module row_buffer
  import transformer_accel_pkg::*;
#(
  parameter  int BITWIDTH = BITWIDTH_DEFAULT,
  parameter  int ROW_LEN  = 8,
  localparam int AW       = $clog2(ROW_LEN)
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [BITWIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [BITWIDTH-1:0] o_rd_data
);

  logic [BITWIDTH-1:0] r_mem [ROW_LEN];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/row_max_drain.sv
// Captures one row from the last-row PE bus while tracking its signed maximum,
// then drains every buffered word minus that maximum, saturated at the bottom.
module row_max_drain
  import transformer_accel_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEFAULT,
  parameter int ROW_LEN  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] row_max,
  output logic                err_overflow
);

  localparam int AW = $clog2(ROW_LEN);
  localparam int CW = count_width(ROW_LEN);
  localparam logic [CW-1:0]       LEN_C = CW'(ROW_LEN);
  localparam logic [BITWIDTH-1:0] MIN_C = {1'b1, {(BITWIDTH-1){1'b0}}};

  row_state_t          r_state;
  logic                r_run;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_idx;
  logic [BITWIDTH-1:0] r_max;
  logic                r_err;

  logic                  w_accept;
  logic                  w_close;
  logic                  w_out_last;
  logic [CW-1:0]         w_count_inc;
  logic [BITWIDTH-1:0]   w_rd_data;
  logic signed [BITWIDTH:0] w_diff;

  // One stage only, so the first state change lands on the second edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign in_ready    = (r_state != ST_DRAIN);
  assign w_accept    = in_valid && in_ready && r_run;
  assign w_count_inc = r_count + 1'b1;
  assign w_close     = in_last || (w_count_inc == LEN_C);
  assign w_out_last  = (r_idx == r_count - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_max   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            r_count <= w_count_inc;
            // First word of a row seeds the maximum; ties keep the older value.
            if ((r_count == '0) || ($signed(in_data) > $signed(r_max))) begin
              r_max <= in_data;
            end
            if (w_close) begin
              r_state <= ST_DRAIN;
              r_err   <= ~in_last;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (w_out_last) begin
              r_state <= ST_IDLE;
              r_count <= '0;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  row_buffer #(
    .BITWIDTH (BITWIDTH),
    .ROW_LEN  (ROW_LEN)
  ) u_row_buffer (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_count[AW-1:0]),
    .i_wr_data (in_data),
    .i_rd_addr (r_idx[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // One extra bit so the difference cannot wrap before saturation is judged.
  assign w_diff = $signed({w_rd_data[BITWIDTH-1], w_rd_data})
                - $signed({r_max[BITWIDTH-1], r_max});

  always_comb begin
    out_data = '0;
    if (r_state == ST_DRAIN) begin
      out_data = (w_diff[BITWIDTH] != w_diff[BITWIDTH-1]) ? MIN_C : w_diff[BITWIDTH-1:0];
    end
  end

  assign out_valid    = (r_state == ST_DRAIN);
  assign out_last     = out_valid && w_out_last;
  assign row_max      = r_max;
  assign err_overflow = r_err;

endmodule
